// File: rtl/param_hs_fifo_pkg.sv
// param_hs_fifo_pkg: width derivations and legal-parameter helpers for param_hs_fifo.
// Revision: 1.0
`default_nettype none

package param_hs_fifo_pkg;

  localparam int unsigned NUM_LEGAL_DW = 2;
  localparam logic [NUM_LEGAL_DW-1:0][7:0] LEGAL_DW = {8'd3, 8'd2};

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int unsigned size_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit is_pow2(input int unsigned value);
    return (value != 0) && ((value & (value - 1)) == 0);
  endfunction

  function automatic bit dw_is_legal(input int unsigned dw);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < NUM_LEGAL_DW; i++) begin
      if (dw == int'(LEGAL_DW[i])) ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

`default_nettype wire

// File: rtl/param_hs_fifo.sv
// param_hs_fifo: valid/ready FIFO with register-array storage and first-word fall-through.
// Revision: 1.0
`default_nettype none

module param_hs_fifo
  import param_hs_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 2,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_WIDTH-1:0]         a_data,
  input  logic                          a_vld,
  output logic                          a_rd,
  output logic [DATA_WIDTH-1:0]         b_data,
  output logic                          b_vld,
  input  logic                          b_rd,
  output logic [size_width(DEPTH)-1:0]  size
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned SW = size_width(DEPTH);

  if (!dw_is_legal(DATA_WIDTH)) begin : g_bad_data_width
    $error("param_hs_fifo: DATA_WIDTH must be 2 or 3");
  end

  if ((DEPTH < 2) || !is_pow2(DEPTH)) begin : g_bad_depth
    $error("param_hs_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [SW-1:0]         size_q,   size_d;
  logic                  push, pop;

  // Handshake flags depend only on occupancy, so no input reaches a_rd or b_vld.
  assign a_rd   = (size_q != SW'(DEPTH));
  assign b_vld  = (size_q != '0);
  assign push   = a_vld & a_rd;
  assign pop    = b_vld & b_rd;
  assign b_data = mem_q[rd_ptr_q];
  assign size   = size_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    size_d   = size_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    if (push && !pop)      size_d = size_q + SW'(1);
    else if (pop && !push) size_d = size_q - SW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      size_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      size_q   <= size_d;
    end
  end

  // Storage is deliberately left out of reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= a_data;
  end

endmodule

`default_nettype wire

// File: doc/param_hs_fifo.md
PARAM_HS_FIFO -- requirements
Module: param_hs_fifo

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 2, giving the payload width in bits; legal values are 2 and 3.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the number of storage entries; it must be a power of two and at least 2.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 Port a_data, input, DATA_WIDTH bits: upstream payload.
REQ-006 Port a_vld, input, 1 bit: upstream payload valid.
REQ-007 Port a_rd, output, 1 bit: the block is ready to accept upstream payload.
REQ-008 Port b_data, output, DATA_WIDTH bits: downstream payload, feeding the a input of the parametrized pass-through unit.
REQ-009 Port b_vld, output, 1 bit: downstream payload valid.
REQ-010 Port b_rd, input, 1 bit: downstream consumer is ready.
REQ-011 Port size, output, clog2(DEPTH+1) bits: current occupancy count.

Function
REQ-012 A push SHALL occur in a cycle iff a_vld=1 and a_rd=1 at the rising edge.
REQ-013 A pop SHALL occur in a cycle iff b_vld=1 and b_rd=1 at the rising edge.
REQ-014 a_rd SHALL be 1 iff size != DEPTH, with no combinational path from b_rd.
REQ-015 b_vld SHALL be 1 iff size != 0, with no combinational path from a_vld.
REQ-016 b_data SHALL equal the entry at the read pointer, read combinationally from the register array (first-word fall-through).
REQ-017 b_data SHALL be don't-care while b_vld=0.
REQ-018 Latency SHALL be exactly one cycle: a word pushed at edge N appears on b_data with b_vld=1 after edge N.
REQ-019 Payload SHALL leave the block in strict push order, unmodified, and bit-exact.
REQ-020 The write pointer and the read pointer SHALL each be clog2(DEPTH) bits and wrap from DEPTH-1 to 0 with no extra logic.
REQ-021 On push alone, size SHALL increment by 1.
REQ-022 On pop alone, size SHALL decrement by 1.
REQ-023 On simultaneous push and pop, size SHALL be unchanged and both pointers SHALL advance.
REQ-024 When full (size=DEPTH), no push SHALL occur even if b_rd=1 in the same cycle; a pop is still allowed.
REQ-025 When empty (size=0), no pop SHALL occur; a push is allowed, and b_vld rises the next cycle.
REQ-026 Holding a_vld=1 while a_rd=0 SHALL NOT alter state.
REQ-027 Payload present while a_vld=0 SHALL be ignored.

Reset
REQ-028 When rst_n=0, asynchronously: write pointer=0, read pointer=0, size=0, hence a_rd=1 and b_vld=0.
REQ-029 Storage entries SHALL NOT be reset.
REQ-030 Reset asserted mid-operation SHALL discard all stored words; the first push after reset release SHALL be the first word popped.
REQ-031 Reset release SHALL take effect at the first rising edge of clk after rst_n goes to 1.

Structure
REQ-032 Package param_hs_fifo_pkg SHALL hold the pointer-width and size-width derivation functions (clog2-based) and the legal DATA_WIDTH list (2, 3).
REQ-033 The block SHALL be a single module with a register-array storage; no sub-module SHALL be instantiated.
REQ-034 The block SHALL elaborate a compile-time error for an illegal DATA_WIDTH or for a DEPTH that is not a power of two.

Verification
REQ-035 Scenario: with DW=2 and D=4, push 1,2,3 with b_rd=0 -> size=3, a_rd=1, b_vld=1, b_data=1.
REQ-036 Scenario: fill to 4 words, then hold a_vld=1 with data 3 -> a_rd=0, size=4, and the held word is not stored.
REQ-037 Scenario: from full, set b_rd=1 and a_vld=1 for one cycle -> only the pop happens, size=3; next cycle both happen, size stays 3.
REQ-038 Scenario: stream 10 words with a_vld=1 and b_rd=1 continuously from empty -> output sequence equals input, and the pointers wrap twice.
REQ-039 Scenario: with DW=3, after 2 words are stored, assert rst_n=0 for one cycle -> size=0 and b_vld=0 immediately; the next pushed word 5 appears on b_data first.
REQ-040 Scenario: random a_vld/b_rd for 1000 cycles with a scoreboard -> no loss, duplication or reordering, and size always matches the model.
